// File: rtl/mem_access_responder.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_responder
// Purpose  : Serialises dcache line and dtlb PTE requests onto one line-wide
//            memory port. Optional macro: MEM_ACCESS_ROUND_ROBIN_EN.
// Revision : 1.0 - initial release
// ============================================================================
module mem_access_responder #(
  parameter int PADDR_WIDTH = 34,
  parameter int LINE_WIDTH  = 128
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [PADDR_WIDTH-1:0]    dcache_addr,
  input  logic                      dcache_read_req,
  input  logic                      dcache_write_req,
  input  logic [LINE_WIDTH-1:0]     dcache_write_value,
  output logic                      dcache_read_grant,
  output logic                      dcache_write_grant,
  output logic [LINE_WIDTH-1:0]     dcache_read_value,
  input  logic [PADDR_WIDTH-1:0]    dtlb_addr,
  input  logic                      dtlb_read_req,
  input  logic                      dtlb_write_req,
  input  logic [31:0]               dtlb_write_value,
  output logic                      dtlb_read_grant,
  output logic                      dtlb_write_grant,
  output logic [31:0]               dtlb_read_value,
  output logic                      mem_req,
  output logic                      mem_we,
  output logic [PADDR_WIDTH-1:0]    mem_addr,
  output logic [LINE_WIDTH-1:0]     mem_wdata,
  output logic [LINE_WIDTH/8-1:0]   mem_wmask,
  input  logic                      mem_ack,
  input  logic [LINE_WIDTH-1:0]     mem_rdata
);

  localparam int c_mask_w    = LINE_WIDTH / 8;
  localparam int c_offs_bits = $clog2(c_mask_w);
  localparam int c_lane_bits = c_offs_bits - 2;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_GRANT  = 2'd2
  } state_t;

  state_t r_state, w_state_nxt;

  logic                   r_src_dtlb;
  logic                   r_we;
  logic [PADDR_WIDTH-1:0] r_addr;
  logic [LINE_WIDTH-1:0]  r_wdata;
  logic [c_mask_w-1:0]    r_wmask;
  logic [c_lane_bits-1:0] r_lane;
  logic [LINE_WIDTH-1:0]  r_line;
  logic [31:0]            r_word;

  logic                   w_dtlb_any;
  logic                   w_dc_any;
  logic                   w_start;
  logic                   w_sel_dtlb;
  logic                   w_sel_we;
  logic [PADDR_WIDTH-1:0] w_sel_addr;
  logic [c_lane_bits-1:0] w_sel_lane;
  logic [LINE_WIDTH-1:0]  w_sel_wdata;
  logic [c_mask_w-1:0]    w_sel_wmask;
  logic                   w_grant;

  assign w_dtlb_any = dtlb_read_req | dtlb_write_req;
  assign w_dc_any   = dcache_read_req | dcache_write_req;
  assign w_start    = (r_state == S_IDLE) & (w_dtlb_any | w_dc_any);

`ifdef MEM_ACCESS_ROUND_ROBIN_EN
  // Records whether the last transaction served dtlb; reset favours dtlb.
  logic r_last_dtlb;

  always_ff @(posedge clk) begin
    if (rst)
      r_last_dtlb <= 1'b0;
    else if (w_start)
      r_last_dtlb <= w_sel_dtlb;
  end

  assign w_sel_dtlb = w_dtlb_any & (~w_dc_any | ~r_last_dtlb);
`else
  assign w_sel_dtlb = w_dtlb_any;
`endif

  // Write beats read inside one requester; the read stays pending.
  always_comb begin
    w_sel_we    = dcache_write_req;
    w_sel_addr  = dcache_addr;
    w_sel_lane  = '0;
    w_sel_wdata = '0;
    w_sel_wmask = '0;
    if (w_sel_dtlb) begin
      w_sel_we   = dtlb_write_req;
      w_sel_addr = dtlb_addr;
    end
    w_sel_lane = w_sel_addr[c_offs_bits-1:2];
    if (w_sel_we) begin
      if (w_sel_dtlb) begin
        w_sel_wdata = LINE_WIDTH'(dtlb_write_value) << (32 * w_sel_lane);
        w_sel_wmask = c_mask_w'(4'hF) << (4 * w_sel_lane);
      end else begin
        w_sel_wdata = dcache_write_value;
        w_sel_wmask = '1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      r_state <= S_IDLE;
    else
      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (w_dtlb_any | w_dc_any) w_state_nxt = S_ACCESS;
      S_ACCESS: if (mem_ack) w_state_nxt = S_GRANT;
      S_GRANT:  w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_src_dtlb <= 1'b0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_wmask    <= '0;
      r_lane     <= '0;
      r_line     <= '0;
      r_word     <= '0;
    end else begin
      if (w_start) begin
        r_src_dtlb <= w_sel_dtlb;
        r_we       <= w_sel_we;
        r_addr     <= w_sel_addr & ~PADDR_WIDTH'(c_mask_w - 1);
        r_wdata    <= w_sel_wdata;
        r_wmask    <= w_sel_wmask;
        r_lane     <= w_sel_lane;
      end
      // The word is extracted at capture so it survives the next latch.
      if ((r_state == S_ACCESS) && mem_ack) begin
        r_line <= mem_rdata;
        r_word <= mem_rdata[32*r_lane +: 32];
      end
    end
  end

  assign w_grant            = (r_state == S_GRANT);
  assign dcache_read_grant  = w_grant & ~r_src_dtlb & ~r_we;
  assign dcache_write_grant = w_grant & ~r_src_dtlb &  r_we;
  assign dtlb_read_grant    = w_grant &  r_src_dtlb & ~r_we;
  assign dtlb_write_grant   = w_grant &  r_src_dtlb &  r_we;

  assign mem_req   = (r_state == S_ACCESS);
  assign mem_we    = r_we;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign mem_wmask = r_wmask;

  assign dcache_read_value = r_line;
  assign dtlb_read_value   = r_word;

endmodule
`default_nettype wire

// File: doc/mem_access_responder.md
MEM_ACCESS_RESPONDER -- requirements
Module: mem_access_responder

Interface
REQ-001 SHALL have parameter PADDR_WIDTH, default 34, physical address width.
REQ-002 SHALL have parameter LINE_WIDTH, default 128, cache line and memory data width in bits.
REQ-003 SHALL have port clk input 1: clock; all state changes on its rising edge.
REQ-004 SHALL have port rst input 1: reset, synchronous, active-high.
REQ-005 SHALL have ports dcache_addr input PADDR_WIDTH, dcache_read_req input 1, dcache_write_req input 1, dcache_write_value input LINE_WIDTH: line requester.
REQ-006 SHALL have ports dcache_read_grant output 1, dcache_write_grant output 1, dcache_read_value output LINE_WIDTH.
REQ-007 SHALL have ports dtlb_addr input PADDR_WIDTH, dtlb_read_req input 1, dtlb_write_req input 1, dtlb_write_value input 32: page-table-entry requester.
REQ-008 SHALL have ports dtlb_read_grant output 1, dtlb_write_grant output 1, dtlb_read_value output 32.
REQ-009 SHALL have ports mem_req output 1, mem_we output 1, mem_addr output PADDR_WIDTH, mem_wdata output LINE_WIDTH, mem_wmask output LINE_WIDTH/8: downstream command.
REQ-010 SHALL have ports mem_ack input 1, mem_rdata input LINE_WIDTH: downstream completion; mem_rdata valid in the mem_ack cycle.

Function
REQ-011 Requests are levels held by the requester until its grant; each grant SHALL be a single-cycle pulse.
REQ-012 FSM states: IDLE, ACCESS, GRANT; IDLE->ACCESS when any request is high; ACCESS->GRANT on mem_ack; GRANT->IDLE unconditionally.
REQ-013 In IDLE the block SHALL select one requester/operation, latch source, op, line-aligned address, write data and mask, and enter ACCESS next cycle.
REQ-014 Within one requester, write SHALL win over a simultaneous read; the read stays pending and is served by a later transaction.
REQ-015 In ACCESS mem_req SHALL be 1 and mem_we, mem_addr, mem_wdata, mem_wmask SHALL equal the latched values and stay stable until mem_ack.
REQ-016 mem_addr SHALL be the request address with bits [$clog2(LINE_WIDTH/8)-1:0] forced to zero.
REQ-017 dcache writes SHALL drive mem_wmask all ones; dtlb writes SHALL place dtlb_write_value in word lane addr[3:2] of mem_wdata with only that lane's 4 mask bits set; addr[1:0] ignored.
REQ-018 On mem_ack the block SHALL capture mem_rdata; dcache_read_value SHALL equal the captured line, dtlb_read_value SHALL equal captured word lane addr[3:2]; both held from GRANT until the next capture.
REQ-019 In GRANT exactly one grant output matching latched source and op SHALL be 1; all grants SHALL be 0 in every other state.
REQ-020 Minimum latency: request seen in IDLE at cycle N, mem_ack at N+1 -> grant at N+2; the next transaction starts no earlier than N+3.
REQ-021 A request dropped during ACCESS SHALL NOT abort the transaction; mem_req remains until mem_ack and the grant still pulses.
REQ-022 mem_ack outside ACCESS SHALL be ignored.
REQ-023 mem_req SHALL be 0 in IDLE and GRANT.

Reset
REQ-024 On rst the FSM SHALL enter IDLE and mem_req, mem_we, all grants, mem_addr, mem_wdata, mem_wmask, dcache_read_value, dtlb_read_value SHALL be 0 from the next cycle.
REQ-025 rst asserted mid-ACCESS SHALL abandon the transaction without a grant; a late mem_ack SHALL be ignored per REQ-022.
REQ-026 Round-robin pointer SHALL reset to favour dtlb.

Configuration
REQ-027 Macro MEM_ACCESS_ROUND_ROBIN_EN defined: on simultaneous dcache and dtlb requests in IDLE, the source not served last SHALL win; pointer updates on each entry to ACCESS.
REQ-028 Macro undefined: dtlb SHALL always win over dcache (fixed priority); no pointer state.

Verification
REQ-029 dcache_read_req, addr 0x0_0000_1234, mem_ack after 2 ACCESS cycles with rdata 0xA..A -> mem_addr 0x1230, mem_we 0, one dcache_read_grant pulse, dcache_read_value 0xA..A.
REQ-030 dtlb_write_req addr 0x8, value 0xDEADBEEF -> mem_wmask 0x0F00, mem_wdata[95:64] 0xDEADBEEF, one dtlb_write_grant pulse.
REQ-031 dtlb and dcache reads held simultaneously, immediate acks -> fixed priority: dtlb, dcache, dtlb...; with MEM_ACCESS_ROUND_ROBIN_EN: dtlb, dcache, dtlb, dcache.
REQ-032 dcache read and write high together -> write granted first, read granted in next transaction.
REQ-033 rst pulsed during ACCESS, mem_ack one cycle later -> no grant, mem_req 0 after reset, FSM in IDLE.
